// File: rtl/operand_stack_if.sv
// Operand stack request/response bundle: the decoder/ALU drives op/data/arg/keep
// and observes the top-of-stack view, occupancy, busy and the error pulse.
interface operand_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  logic [DEPTH:0]   arg;
  logic [DEPTH:0]   keep;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [DEPTH:0]   count;
  logic [1:0]       status;
  logic             busy;
  logic [1:0]       error;

  modport master (
    output op, data, arg, keep,
    input  tos, nos, count, status, busy, error
  );
  modport slave (
    input  op, data, arg, keep,
    output tos, nos, count, status, busy, error
  );
endinterface

// File: rtl/operand_stack.sv
// WebAssembly operand stack: push/pop/replace/binary/dropn plus multi-cycle block unwind.
// OPERAND_STACK_UNWIND_EN builds UNWIND and its COPY FSM; otherwise op 6 is ILLEGAL.
module operand_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  operand_stack_if.slave sb
);
  localparam int CAP = 2**DEPTH;
  localparam int CW  = DEPTH + 1;
  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_BINARY  = 3'd4;
  localparam logic [2:0] OP_DROPN   = 3'd5;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;

  logic [WIDTH-1:0] mem [CAP];
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       err_q, err_n;
  logic             we;
  logic [DEPTH-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic [DEPTH-1:0] top_i, nxt_i;

  assign top_i = DEPTH'(cnt - CW'(1));
  assign nxt_i = DEPTH'(cnt - CW'(2));

`ifdef OPERAND_STACK_UNWIND_EN
  localparam logic [2:0] OP_UNWIND = 3'd6;
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COPY    = 1'b1;

  logic [0:0]       st;
  logic [DEPTH-1:0] src, dst;
  logic [CW-1:0]    rem, uarg;
  logic             go_copy;
  logic [CW:0]      ka_sum;
  logic [CW-1:0]    base;

  // one extra bit so keep+arg cannot wrap past count
  assign ka_sum = {1'b0, sb.keep} + {1'b0, sb.arg};
  assign base   = cnt - sb.keep - sb.arg;
  assign busy   = (st == S_COPY);
`else
  logic unused_keep;
  assign unused_keep = ^sb.keep;
  assign busy        = 1'b0;
`endif

  always_comb begin
    cnt_n = cnt;
    err_n = E_NONE;
    we    = 1'b0;
    waddr = top_i;
    wdata = sb.data;
`ifdef OPERAND_STACK_UNWIND_EN
    go_copy = 1'b0;
    // copies run upward: destination always sits below source
    if (busy) begin
      we    = 1'b1;
      waddr = dst;
      wdata = mem[src];
      if (rem == CW'(1)) cnt_n = cnt - uarg;
    end else
`endif
    if (sb.op != OP_NONE) begin
      case (sb.op)
        OP_PUSH:
          if (cnt == CAP_C) err_n = E_OVER;
          else begin
            we    = 1'b1;
            waddr = cnt[DEPTH-1:0];
            cnt_n = cnt + CW'(1);
          end
        OP_POP:
          if (cnt == '0) err_n = E_UNDER;
          else cnt_n = cnt - CW'(1);
        OP_REPLACE:
          if (cnt == '0) err_n = E_UNDER;
          else we = 1'b1;
        OP_BINARY:
          if (cnt < CW'(2)) err_n = E_UNDER;
          else begin
            we    = 1'b1;
            waddr = nxt_i;
            cnt_n = cnt - CW'(1);
          end
        OP_DROPN:
          if (sb.arg > cnt) err_n = E_UNDER;
          else cnt_n = cnt - sb.arg;
`ifdef OPERAND_STACK_UNWIND_EN
        OP_UNWIND:
          if (ka_sum > {1'b0, cnt}) err_n = E_UNDER;
          else if (sb.keep == '0 || sb.arg == '0) cnt_n = cnt - sb.arg;
          else go_copy = 1'b1;
`endif
        default: err_n = E_ILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      err_q <= E_NONE;
    end else begin
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

`ifdef OPERAND_STACK_UNWIND_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= S_IDLE;
      rem  <= '0;
      uarg <= '0;
      src  <= '0;
      dst  <= '0;
    end else if (st == S_IDLE) begin
      if (go_copy) begin
        st   <= S_COPY;
        rem  <= sb.keep;
        uarg <= sb.arg;
        dst  <= base[DEPTH-1:0];
        src  <= DEPTH'(base + sb.arg);
      end
    end else begin
      dst <= dst + DEPTH'(1);
      src <= src + DEPTH'(1);
      rem <= rem - CW'(1);
      if (rem == CW'(1)) st <= S_IDLE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign sb.tos    = (cnt == '0)     ? '0 : mem[top_i];
  assign sb.nos    = (cnt < CW'(2))  ? '0 : mem[nxt_i];
  assign sb.count  = cnt;
  assign sb.status = (cnt == '0) ? 2'd1 : (cnt == CAP_C) ? 2'd2 : 2'd0;
  assign sb.busy   = busy;
  assign sb.error  = err_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: queue-level model checked every cycle plus literal anchors.
module tb_operand_stack;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_stack_if #(.WIDTH(32), .DEPTH(4)) bus ();
  operand_stack #(.WIDTH(32), .DEPTH(4)) dut (.clk(clk), .reset(rst_n), .sb(bus));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [31:0] mq[$];
  bit m_busy;
  int m_left, m_base, m_arg, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_tos();
    return (mq.size() > 0) ? mq[mq.size()-1] : 32'd0;
  endfunction
  function automatic logic [31:0] m_nos();
    return (mq.size() > 1) ? mq[mq.size()-2] : 32'd0;
  endfunction
  function automatic logic [31:0] m_status();
    return (mq.size() == 0) ? 32'd1 : (mq.size() == 16) ? 32'd2 : 32'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_left = 0;
    m_err  = 0;
  endtask

  // Applies the op on the inputs at this rising edge to the queue model.
  task automatic model_step();
    int n, a, k;
    n = mq.size();
    a = int'(bus.arg);
    k = int'(bus.keep);
    m_err = 0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        repeat (m_arg) mq.delete(m_base);
        m_busy = 1'b0;
      end
    end else begin
      case (bus.op)
        3'd1: if (n == 16) m_err = 2; else mq.push_back(bus.data);
        3'd2: if (n == 0) m_err = 1; else void'(mq.pop_back());
        3'd3: if (n == 0) m_err = 1; else mq[n-1] = bus.data;
        3'd4: if (n < 2) m_err = 1; else begin void'(mq.pop_back()); mq[n-2] = bus.data; end
        3'd5: if (a > n) m_err = 1; else repeat (a) void'(mq.pop_back());
`ifdef OPERAND_STACK_UNWIND_EN
        3'd6:
          if (k + a > n) m_err = 1;
          else if (k == 0 || a == 0) repeat (a) mq.delete(n - k - a);
          else begin
            m_busy = 1'b1;
            m_left = k;
            m_base = n - k - a;
            m_arg  = a;
          end
`else
        3'd6: m_err = 3;
`endif
        3'd7: m_err = 3;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] d, input int a, input int k);
    bus.op   = op;
    bus.data = d;
    bus.arg  = 5'(a);
    bus.keep = 5'(k);
    tick();
    bus.op = 3'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count",  32'(bus.count),  32'(mq.size()));
      chk("tos",    bus.tos,         m_tos());
      chk("nos",    bus.nos,         m_nos());
      chk("status", 32'(bus.status), m_status());
      chk("busy",   32'(bus.busy),   32'(m_busy));
      chk("error",  32'(bus.error),  32'(m_err));
    end
  end

  initial begin
    rst_n    = 1'b0;
    bus.op   = 3'd0;
    bus.data = '0;
    bus.arg  = '0;
    bus.keep = '0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_status", 32'(bus.status), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // fill to capacity, then overflow
    for (int v = 1; v <= 16; v++) do_op(3'd1, 32'(v), 0, 0);
    chk("full_status", 32'(bus.status), 32'd2);
    chk("full_tos", bus.tos, 32'd16);
    chk("full_nos", bus.nos, 32'd15);
    do_op(3'd1, 32'd17, 0, 0);
    chk("ovf_error", 32'(bus.error), 32'd2);
    chk("ovf_count", 32'(bus.count), 32'd16);
    tick();
    chk("ovf_pulse_end", 32'(bus.error), 32'd0);

    // underflow and fused binary
    do_reset();
    do_op(3'd2, 0, 0, 0);
    chk("pop_empty_err", 32'(bus.error), 32'd1);
    do_op(3'd1, 32'd7, 0, 0);
    do_op(3'd4, 32'd9, 0, 0);
    chk("bin_under_err", 32'(bus.error), 32'd1);
    do_op(3'd1, 32'd5, 0, 0);
    do_op(3'd4, 32'd12, 0, 0);
    chk("bin_count", 32'(bus.count), 32'd1);
    chk("bin_tos", bus.tos, 32'd12);
    chk("bin_nos", bus.nos, 32'd0);
    do_op(3'd3, 32'd33, 0, 0);
    chk("replace_tos", bus.tos, 32'd33);

    // multi-drop
    do_reset();
    for (int v = 1; v <= 5; v++) do_op(3'd1, 32'(v * 10), 0, 0);
    do_op(3'd5, 0, 3, 0);
    chk("dropn_count", 32'(bus.count), 32'd2);
    chk("dropn_tos", bus.tos, 32'd20);
    do_op(3'd5, 0, 3, 0);
    chk("dropn_under", 32'(bus.error), 32'd1);
    do_op(3'd5, 0, 0, 0);
    chk("dropn0_count", 32'(bus.count), 32'd2);
    do_op(3'd7, 0, 0, 0);
    chk("op7_illegal", 32'(bus.error), 32'd3);

`ifdef OPERAND_STACK_UNWIND_EN
    do_reset();
    for (int v = 1; v <= 8; v++) do_op(3'd1, 32'(v), 0, 0);
    do_op(3'd6, 0, 4, 2);
    chk("unw_busy0", 32'(bus.busy), 32'd1);
    chk("unw_hold_count", 32'(bus.count), 32'd8);
    do_op(3'd1, 32'd99, 0, 0);
    chk("unw_busy1", 32'(bus.busy), 32'd1);
    tick();
    chk("unw_done_busy", 32'(bus.busy), 32'd0);
    chk("unw_count", 32'(bus.count), 32'd4);
    chk("unw_tos", bus.tos, 32'd8);
    chk("unw_nos", bus.nos, 32'd7);
    do_op(3'd2, 0, 0, 0);
    do_op(3'd2, 0, 0, 0);
    chk("unw_low_tos", bus.tos, 32'd2);
    chk("unw_low_nos", bus.nos, 32'd1);

    do_reset();
    for (int v = 1; v <= 6; v++) do_op(3'd1, 32'(v), 0, 0);
    do_op(3'd6, 0, 4, 3);
    chk("unw_under", 32'(bus.error), 32'd1);
    chk("unw_under_count", 32'(bus.count), 32'd6);
    do_op(3'd6, 0, 2, 0);
    chk("unw_k0_count", 32'(bus.count), 32'd4);
    do_op(3'd6, 0, 1, 3);
    chk("unw_mid_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    do_reset();
    for (int v = 1; v <= 3; v++) do_op(3'd1, 32'(v), 0, 0);
    do_op(3'd6, 0, 1, 1);
    chk("op6_illegal", 32'(bus.error), 32'd3);
    chk("op6_count", 32'(bus.count), 32'd3);
    chk("op6_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("op6_busy_after", 32'(bus.busy), 32'd0);
`endif

    repeat (2) tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
